// File: rtl/bexkat1_pkg.sv
// Shared types and constants for the bexkat1 instruction-side blocks.
// Holds the prefetch FSM state type and the FIFO entry layout.
package bexkat1_pkg;

    localparam int INS_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        PF_RUN   = 2'd0,
        PF_DRAIN = 2'd1,
        PF_FLUSH = 2'd2
    } pf_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } pf_entry_t;

endpackage

// File: rtl/pf_fifo.sv
// Show-ahead FIFO of {pc, word} entries for the instruction prefetcher.
// Synchronous clear has priority over push and pop; count is exported for credit logic.
module pf_fifo
    import bexkat1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr,
    input  logic                     push,
    input  pf_entry_t                din,
    input  logic                     pop,
    output pf_entry_t                dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    pf_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO may accept a push in the same cycle it pops.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ins_prefetch.sv
// Instruction prefetch buffer: pipelined Wishbone reads ahead of ifetch into a show-ahead FIFO.
// Optional PREFETCH_STATS_EN adds flush and delivered-word counters.
module ins_prefetch
    import bexkat1_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_set_i,
    input  logic [31:0] pc_in,
    input  logic        halt_i,
    output logic [31:0] word_o,
    output logic [31:0] word_pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] bus_adr_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    input  logic        bus_stall_i
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0] stat_flush_o,
    output logic [31:0] stat_words_o
`endif
);
    localparam int          AW   = $clog2(DEPTH);
    localparam int          CW   = AW + 1;
    localparam logic [31:0] STEP = 32'(INS_WORD_BYTES);

    pf_state_t     state;
    pf_state_t     state_nx;
    logic [31:0]   adr;
    logic [31:0]   tag;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   load;
    logic          credit;
    logic          busy;
    logic          cyc;
    logic          stb;
    logic          issue;
    logic          ack_take;
    logic          pop;
    logic          fifo_empty;
    pf_entry_t     head;
    pf_entry_t     ack_entry;

    // Reserving a slot per outstanding read guarantees every ack finds room.
    assign load     = {1'b0, fifo_count} + {1'b0, outstanding};
    assign credit   = (load < (CW+1)'(DEPTH));
    assign busy     = (outstanding != '0);
    assign issue    = stb & ~bus_stall_i;
    assign ack_take = bus_ack_i & (state != PF_FLUSH) & busy;
    assign pop      = valid_o & ready_i;

    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        cyc = 1'b0;
        stb = 1'b0;
        case (state)
            PF_RUN: begin
                stb = credit;
                cyc = credit | busy;
            end
            PF_DRAIN: cyc = busy;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (pc_set_i) begin
            state_nx = PF_FLUSH;
        end else begin
            case (state)
                PF_RUN:   if (halt_i) state_nx = PF_DRAIN;
                PF_DRAIN: state_nx = PF_DRAIN;
                default:  state_nx = PF_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= PF_RUN;
            adr         <= RESET_VEC;
            tag         <= RESET_VEC;
            outstanding <= '0;
        end else begin
            state <= state_nx;
            if (pc_set_i) begin
                adr         <= pc_in;
                tag         <= pc_in;
                outstanding <= '0;
            end else begin
                if (issue)    adr <= adr + STEP;
                if (ack_take) tag <= tag + STEP;
                outstanding <= outstanding + CW'(issue) - CW'(ack_take);
            end
        end
    end

    assign ack_entry = '{pc: tag, word: bus_dat_i};

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (pc_set_i),
        .push  (ack_take),
        .din   (ack_entry),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus strobes are masked by reset so they drop the instant reset asserts.
    assign bus_cyc_o = rst_i & cyc;
    assign bus_stb_o = rst_i & stb;
    assign bus_adr_o = adr;
    assign bus_we_o  = 1'b0;
    assign bus_sel_o = 4'hf;
    assign valid_o   = ~fifo_empty;
    assign word_o    = valid_o ? head.word : '0;
    assign word_pc_o = valid_o ? head.pc : '0;

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_flush_o <= '0;
            stat_words_o <= '0;
        end else begin
            if (pc_set_i) stat_flush_o <= stat_flush_o + 16'd1;
            if (pop)      stat_words_o <= stat_words_o + 32'd1;
        end
    end
`endif

endmodule
